hazard_scoreboard_ctrl: RTL and testbench
=========================================

// Module: hazard_scoreboard_ctrl
// PURPOSE
//  Parametrised pipeline stall controller for the 6-stage core (PC/IF/ID/EX/MEM/WB).
//  Generalises the single-cycle load-use check to NUM_SRC read ports and multi-cycle producers.
//  A per-register countdown scoreboard tracks the cycles left until each result is forwardable.
//  Merges the data-hazard stall with the memory-wait stall and emits one stall vector.
//  Keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  NUM_SRC     2   number of ID-stage source operands checked
//  REG_ADDR_W  5   register address width (matches REG_LENGTH_IN_INST)
//  NUM_REGS    32  architectural registers; reg 0 is hardwired and never hazards
//  MAX_LAT     4   largest producer latency accepted on ex_lat_i
//  LAT_W       3   width of ex_lat_i and the counters; must hold MAX_LAT
//  PERF_W      16  width of the stall performance counter
// PORTS
//  clk           in   1                     core clock; all state updates on rising edge
//  rst           in   1                     synchronous, active-low reset
//  ex_valid_i    in   1                     EX holds a real instruction (0 = bubble)
//  ex_wreg_i     in   1                     EX instruction writes a register
//  ex_reg3_i     in   REG_ADDR_W            EX destination register
//  ex_lat_i      in   LAT_W                 cycles after EX before result is forwardable (0 = ALU, 1 = load)
//  id_reg_i      in   NUM_SRC*REG_ADDR_W    ID source registers, packed; src k at [k*REG_ADDR_W +: REG_ADDR_W]
//  id_regRead_i  in   NUM_SRC               per-source read enable
//  mem_busy_i    in   1                     data memory wait request
//  stall_o       out  6                     [5]PC [4]IF [3]ID [2]EX [1]MEM [0]WB; 1 = hold stage
//  hazard_o      out  1                     data-hazard stall active this cycle
//  stall_cnt_o   out  PERF_W                saturating count of cycles with stall_o != 0
// BEHAVIOUR
//  Reset (rst==0 at an edge):
//   - clears all counters and stall_cnt_o;
//   - stall_o=0 and hazard_o=0 while rst is low (combinational override).
//  Issue:
//   - issue = ex_valid_i & ex_wreg_i & (ex_reg3_i!=0) & (ex_lat_i!=0) & ~mem_busy_i.
//   - On the edge: cnt[ex_reg3_i] <= ex_lat_i-1.
//   - ex_lat_i > MAX_LAT is clamped to MAX_LAT.
//  Decrement:
//   - each edge with mem_busy_i==0, every nonzero cnt not being issued decrements by 1;
//   - counters never wrap below 0.
//  Freeze: while mem_busy_i==1 all counters hold and no issue is recorded.
//  WAW: issue to a register with cnt!=0 overwrites cnt with the new value. No max is taken.
//  Source k is hazardous (combinational) when id_regRead_i[k] & (id_reg k != 0) and either:
//   - (a) cnt[id_reg k] != 0, or
//   - (b) ex_valid_i & ex_wreg_i & ex_lat_i!=0 & ex_reg3_i==id_reg k (covers the load-use cycle).
//  hazard_o = OR over all sources.
//  stall_o priority:
//   - mem_busy_i          -> 6'b111_110
//   - else hazard_o       -> 6'b111_000 (EX takes a bubble)
//   - else                -> 6'b000_000
//  Resulting latency:
//   - load (lat 1) followed by a dependent instruction costs exactly 1 bubble;
//   - a lat-L producer costs L bubbles when the dependent immediately follows;
//   - no mem stall is assumed in either case.
//  Because EX is bubbled, a stalled consumer never re-triggers (b) on the following cycle.
//  stall_cnt_o increments on each edge with stall_o!=0 and saturates at all-ones.
//  Reset mid-operation (counters nonzero) discards all pending hazards on that edge.
// STRUCTURE
//  Add to defines.v:
//   - `STALL_NONE / `STALL_LOADUSE / `STALL_MEM vector constants;
//   - stall bit index macros;
//   - `LAT_ALU=0 and `LAT_LOAD=1.
//  Sub-module sb_counter: one LAT_W down-counter with load, decrement, freeze and sync reset.
//  Instantiate NUM_REGS-1 copies via generate (reg 0 omitted).
//  Top level holds the hazard compare tree, the priority mux and the perf counter.
// TESTING
//  1 lod r3 in EX (lat 1), ID reads r3 on src0 -> stall_o=111_000 for 1 cycle, then 000_000; stall_cnt_o=1.
//  2 mul r5 lat 3, dependent next -> hazard_o high 3 consecutive cycles; dependent 2 later -> 1 cycle.
//  3 lat 3 to r5 while mem_busy_i held 4 cycles -> stall_o=111_110 x4, cnt frozen; then 2 hazard cycles.
//  4 r0 as destination or source, or id_regRead_i=0 -> never stall; lat 4 to r7 then lat 1 to r7 -> cnt=0.
//  5 reset asserted with cnt[r9]=3 -> stall_o=0 during reset; after release reading r9 does not stall.
//  6 force 2^PERF_W+5 stall cycles -> stall_cnt_o saturates at all-ones and holds.

Source files
------------

// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// Shared constants for the hazard scoreboard: stall vector encodings, stall bit indices and producer latencies.
package hazard_scoreboard_ctrl_pkg;

    localparam int STALL_W   = 6;
    localparam int STALL_PC  = 5;
    localparam int STALL_IF  = 4;
    localparam int STALL_ID  = 3;
    localparam int STALL_EX  = 2;
    localparam int STALL_MEM = 1;
    localparam int STALL_WB  = 0;

    localparam logic [STALL_W-1:0] STALL_NONE    = 6'b000_000;
    localparam logic [STALL_W-1:0] STALL_LOADUSE = 6'b111_000;
    localparam logic [STALL_W-1:0] STALL_MEMWAIT = 6'b111_110;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;

    // Memory wait dominates; a data hazard holds PC/IF/ID and lets EX take a bubble.
    function automatic logic [STALL_W-1:0] stall_sel(input logic mem_busy, input logic hazard);
        logic [STALL_W-1:0] v;
        v = STALL_NONE;
        if (mem_busy)
            v = STALL_MEMWAIT;
        else if (hazard)
            v = STALL_LOADUSE;
        return v;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_ctrl_sb_counter.sv
// One scoreboard entry: cycles left until a register's pending result becomes forwardable.
// Load wins over decrement; counting pauses while run_i is low and never wraps below zero.
module sb_counter #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    input  logic             run_i,
    output logic [LAT_W-1:0] cnt_o
);

    logic [LAT_W-1:0] cnt_d;
    logic [LAT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (run_i && (cnt_q != '0))
            cnt_d = cnt_q - LAT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Stall controller: per-register countdown scoreboard, source hazard compare, stall priority mux and perf counter.
// Stall outputs are combinational from current inputs and scoreboard state; a memory wait freezes the scoreboard.
module hazard_scoreboard_ctrl
    import hazard_scoreboard_ctrl_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int MAX_LAT    = 4,
    parameter int LAT_W      = 3,
    parameter int PERF_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ex_valid_i,
    input  logic                          ex_wreg_i,
    input  logic [REG_ADDR_W-1:0]         ex_reg3_i,
    input  logic [LAT_W-1:0]              ex_lat_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_reg_i,
    input  logic [NUM_SRC-1:0]            id_regRead_i,
    input  logic                          mem_busy_i,
    output logic [STALL_W-1:0]            stall_o,
    output logic                          hazard_o,
    output logic [PERF_W-1:0]             stall_cnt_o
);

    logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
    logic [LAT_W-1:0]               lat_clamped;
    logic [LAT_W-1:0]               load_val;
    logic                           ex_produces;
    logic                           issue;
    logic                           hazard;
    logic [STALL_W-1:0]             stall;
    logic [PERF_W-1:0]              stall_cnt_d;
    logic [PERF_W-1:0]              stall_cnt_q;

    assign ex_produces = ex_valid_i & ex_wreg_i & (ex_lat_i != '0);
    assign issue       = ex_produces & (ex_reg3_i != '0) & ~mem_busy_i;
    assign lat_clamped = (ex_lat_i > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : ex_lat_i;
    assign load_val    = lat_clamped - LAT_W'(1);

    // Register 0 is hardwired, so it gets no counter and always reads as ready.
    assign cnt[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
        sb_counter #(
            .LAT_W(LAT_W)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .load_i     (issue && (ex_reg3_i == REG_ADDR_W'(r))),
            .load_val_i (load_val),
            .run_i      (~mem_busy_i),
            .cnt_o      (cnt[r])
        );
    end

    always_comb begin
        logic [REG_ADDR_W-1:0] src;
        hazard = 1'b0;
        src    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src = id_reg_i[k*REG_ADDR_W +: REG_ADDR_W];
            // The EX-stage compare catches the producer before its counter has been written.
            if (id_regRead_i[k] && (src != '0) &&
                ((cnt[src] != '0) || (ex_produces && (ex_reg3_i == src))))
                hazard = 1'b1;
        end
    end

    always_comb begin
        stall = STALL_NONE;
        if (rst)
            stall = stall_sel(mem_busy_i, hazard);
    end

    assign stall_o  = stall;
    assign hazard_o = rst & hazard;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((stall != STALL_NONE) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench for hazard_scoreboard_ctrl: a cycle-by-cycle vector table plus hand sequences for freeze, reset and saturation.
module tb_hazard_scoreboard_ctrl;

    localparam logic [5:0] S_N = 6'b000_000;
    localparam logic [5:0] S_H = 6'b111_000;
    localparam logic [5:0] S_M = 6'b111_110;

    typedef struct {
        logic        rst;
        logic        ev;
        logic        ew;
        logic [4:0]  rd3;
        logic [2:0]  lat;
        logic [4:0]  s0;
        logic [4:0]  s1;
        logic [1:0]  re;
        logic        busy;
        logic [5:0]  stall;
        logic        haz;
        logic [15:0] cnt;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        ex_valid_i;
    logic        ex_wreg_i;
    logic [4:0]  ex_reg3_i;
    logic [2:0]  ex_lat_i;
    logic [9:0]  id_reg_i;
    logic [1:0]  id_regRead_i;
    logic        mem_busy_i;
    logic [5:0]  stall_o;
    logic        hazard_o;
    logic [15:0] stall_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_scoreboard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid_i   (ex_valid_i),
        .ex_wreg_i    (ex_wreg_i),
        .ex_reg3_i    (ex_reg3_i),
        .ex_lat_i     (ex_lat_i),
        .id_reg_i     (id_reg_i),
        .id_regRead_i (id_regRead_i),
        .mem_busy_i   (mem_busy_i),
        .stall_o      (stall_o),
        .hazard_o     (hazard_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic ev, input logic ew, input logic [4:0] rd3,
                                input logic [2:0] lat, input logic [4:0] s0, input logic [4:0] s1,
                                input logic [1:0] re, input logic busy, input logic [5:0] stall,
                                input logic haz, input logic [15:0] cnt);
        vec_t v;
        v.rst = r;   v.ev = ev;   v.ew = ew;     v.rd3 = rd3; v.lat = lat; v.s0 = s0;
        v.s1 = s1;   v.re = re;   v.busy = busy; v.stall = stall; v.haz = haz; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Drive one cycle's inputs just after the edge, check mid-cycle, then advance past the next edge.
    task automatic step(input vec_t v, input string tag);
        rst          = v.rst;
        ex_valid_i   = v.ev;
        ex_wreg_i    = v.ew;
        ex_reg3_i    = v.rd3;
        ex_lat_i     = v.lat;
        id_reg_i     = {v.s1, v.s0};
        id_regRead_i = v.re;
        mem_busy_i   = v.busy;
        #4;
        chk({tag, " stall_o"}, 32'(stall_o), 32'(v.stall));
        chk({tag, " hazard_o"}, 32'(hazard_o), 32'(v.haz));
        chk({tag, " stall_cnt_o"}, 32'(stall_cnt_o), 32'(v.cnt));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[22];

    initial begin
        tbl[0]  = mk(1, 1,1, 3,1,  3, 0,2'b01,0, S_H,1,0);
        tbl[1]  = mk(1, 0,0, 0,0,  3, 0,2'b01,0, S_N,0,1);
        tbl[2]  = mk(1, 1,1, 5,3,  0, 5,2'b10,0, S_H,1,1);
        tbl[3]  = mk(1, 0,0, 0,0,  0, 5,2'b10,0, S_H,1,2);
        tbl[4]  = mk(1, 0,0, 0,0,  0, 5,2'b10,0, S_H,1,3);
        tbl[5]  = mk(1, 0,0, 0,0,  0, 5,2'b10,0, S_N,0,4);
        tbl[6]  = mk(1, 1,1, 5,3,  6, 0,2'b01,0, S_N,0,4);
        tbl[7]  = mk(1, 1,1, 8,0,  1, 0,2'b01,0, S_N,0,4);
        tbl[8]  = mk(1, 1,0, 5,2,  5, 0,2'b01,0, S_H,1,4);
        tbl[9]  = mk(1, 0,0, 0,0,  5, 0,2'b01,0, S_N,0,5);
        tbl[10] = mk(1, 1,1, 0,3,  0, 0,2'b11,0, S_N,0,5);
        tbl[11] = mk(1, 0,0, 0,0,  0, 0,2'b11,0, S_N,0,5);
        tbl[12] = mk(1, 1,1, 7,4,  7, 7,2'b00,0, S_N,0,5);
        tbl[13] = mk(1, 1,1, 7,1,  7, 0,2'b01,0, S_H,1,5);
        tbl[14] = mk(1, 0,0, 0,0,  7, 7,2'b11,0, S_N,0,6);
        tbl[15] = mk(1, 1,1,10,7,  0, 0,2'b00,0, S_N,0,6);
        tbl[16] = mk(1, 0,0, 0,0,  0,10,2'b10,0, S_H,1,6);
        tbl[17] = mk(1, 0,0, 0,0,  0,10,2'b10,0, S_H,1,7);
        tbl[18] = mk(1, 0,0, 0,0,  0,10,2'b10,0, S_H,1,8);
        tbl[19] = mk(1, 0,0, 0,0,  0,10,2'b10,0, S_N,0,9);
        tbl[20] = mk(1, 0,1,12,2, 12, 0,2'b01,0, S_N,0,9);
        tbl[21] = mk(1, 0,0, 0,0, 12, 0,2'b01,0, S_N,0,9);

        rst = 1'b0; ex_valid_i = 1'b0; ex_wreg_i = 1'b0; ex_reg3_i = '0; ex_lat_i = '0;
        id_reg_i = '0; id_regRead_i = '0; mem_busy_i = 1'b0;
        @(posedge clk);
        #1;
        // Reset overrides even a memory wait.
        step(mk(0, 0,0,0,0, 3,0,2'b01,1, S_N,0,0), "reset");

        for (int i = 0; i < 22; i++)
            step(tbl[i], $sformatf("vec%0d", i));

        // Memory wait freezes the scoreboard and blocks new issue.
        step(mk(1, 1,1, 5,3, 5,0,2'b01,0, S_H,1,9),  "frz0");
        step(mk(1, 0,0, 0,0, 5,0,2'b01,1, S_M,1,10), "frz1");
        step(mk(1, 1,1,11,3, 5,0,2'b01,1, S_M,1,11), "frz2");
        step(mk(1, 0,0, 0,0, 5,0,2'b01,1, S_M,1,12), "frz3");
        step(mk(1, 0,0, 0,0, 5,0,2'b01,1, S_M,1,13), "frz4");
        step(mk(1, 0,0, 0,0, 5,0,2'b01,0, S_H,1,14), "frz5");
        step(mk(1, 0,0, 0,0, 5,0,2'b01,0, S_H,1,15), "frz6");
        step(mk(1, 0,0, 0,0, 5,0,2'b01,0, S_N,0,16), "frz7");
        step(mk(1, 0,0, 0,0,11,0,2'b01,0, S_N,0,16), "frz8");

        // Reset with a pending hazard on r9 discards it.
        step(mk(1, 1,1, 9,4, 0,0,2'b00,0, S_N,0,16), "rst0");
        step(mk(0, 0,0, 0,0, 9,0,2'b01,0, S_N,0,16), "rst1");
        step(mk(1, 0,0, 0,0, 9,0,2'b01,0, S_N,0,0),  "rst2");

        // Saturation of the perf counter under a long memory wait.
        mem_busy_i = 1'b1; id_regRead_i = '0;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat pre", 32'(stall_cnt_o), 32'hFFFE);
        chk("sat stall_o", 32'(stall_o), 32'(S_M));
        @(posedge clk);
        #1;
        chk("sat reach", 32'(stall_cnt_o), 32'hFFFF);
        repeat (6) @(posedge clk);
        #1;
        chk("sat hold", 32'(stall_cnt_o), 32'hFFFF);
        step(mk(1, 0,0, 0,0, 0,0,2'b00,0, S_N,0,16'hFFFF), "sat idle");
        chk("sat after idle", 32'(stall_cnt_o), 32'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
